// File: rtl/ctrl_seq_decoder.sv
// Registered control decoder: valid/ready intake, put-chunk immediate assembly, load stall.
// Define CTRL_ILLEGAL_TRAP_EN to add a sticky 'illegal' output for opcodes 1110/1111.
module ctrl_seq_decoder #(
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    input  logic [8:0]    instr,
    output logic          instr_ready,
    output logic          ctl_valid,
    output logic [5:0]    ctl_flags,
    output logic [3:0]    ALUOp,
    output logic [DW-1:0] value,
    output logic          imm_full
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic          illegal
`endif
);
    localparam int NCH = DW / 8;
    localparam int CW  = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [DW-1:0] acc;
    logic [2:0]    put_cnt;
    logic          accept;
    logic          is_put;
    logic [3:0]    opcode;
    logic [7:0]    payload;
    logic [DW-1:0] payload_ext;
    logic [5:0]    dec_flags;
    logic [3:0]    dec_alu;

    assign instr_ready = (state == RUN);
    assign accept      = instr_valid && instr_ready;
    assign is_put      = instr[0];
    assign opcode      = instr[4:1];
    assign payload     = instr[8:1];
    assign payload_ext = DW'(payload);
    assign imm_full    = (put_cnt == 3'(NCH));

    // Flag order: {branch, memToReg, memWrite, regWrite, immtoReg, opEn}
    always_comb begin
        dec_flags = 6'b000101;
        dec_alu   = 4'b1111;
        case (opcode)
            4'b0000: dec_flags = 6'b000111;
            4'b0001: dec_flags = 6'b010101;
            4'b0010: dec_flags = 6'b001001;
            4'b0011: dec_alu   = 4'b0101;
            4'b0100: dec_alu   = 4'b0110;
            4'b0101: dec_alu   = 4'b0001;
            4'b0110: dec_alu   = 4'b0010;
            4'b0111: dec_alu   = 4'b0000;
            4'b1000: dec_flags = 6'b100001;
            4'b1001: begin dec_flags = 6'b000001; dec_alu = 4'b1001; end
            4'b1010: begin dec_flags = 6'b000001; dec_alu = 4'b0111; end
            4'b1011: begin dec_flags = 6'b000001; dec_alu = 4'b1000; end
            4'b1100: dec_alu   = 4'b0011;
            4'b1101: dec_alu   = 4'b0100;
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                dec_flags = 6'b000000;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            acc       <= '0;
            put_cnt   <= '0;
            ctl_valid <= 1'b0;
            ctl_flags <= '0;
            ALUOp     <= 4'b1111;
            value     <= '0;
        end else begin
            ctl_valid <= 1'b0;
            ctl_flags <= '0;
            ALUOp     <= 4'b1111;
            if (state == WAIT) begin
                if (wait_cnt <= CW'(1))
                    state <= RUN;
                wait_cnt <= wait_cnt - CW'(1);
            end
            if (accept) begin
                if (is_put) begin
                    // Shifting keeps the newest NCH bytes once the count saturates
                    acc <= (acc << 8) | payload_ext;
                    if (put_cnt != 3'(NCH))
                        put_cnt <= put_cnt + 3'd1;
                end else begin
                    ctl_valid <= 1'b1;
                    ctl_flags <= dec_flags;
                    ALUOp     <= dec_alu;
                    value     <= (put_cnt != 3'd0) ? acc : payload_ext;
                    acc       <= '0;
                    put_cnt   <= '0;
                    if (MEM_LAT > 0 && opcode == 4'b0001) begin
                        state    <= WAIT;
                        wait_cnt <= CW'(MEM_LAT);
                    end
                end
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal <= 1'b0;
        else if (accept && !is_put && opcode[3:1] == 3'b111)
            illegal <= 1'b1;
    end
`endif

endmodule
